// File: rtl/order_ref_tracker_if.sv
// Add/Delete event bus between the message decoders and order_ref_tracker.
// Optional statistics outputs are present only when ORDER_TRACKER_STATS_EN is defined.
//
// Handshake: add_internal_valid and delete_internal_valid are single-cycle
// pulses with no ready; the tracker accepts one add and one delete every cycle.
// Every trk_* pulse is registered and follows its event by exactly one cycle.
interface order_ref_tracker_if #(
    parameter int DEPTH = 16
);
    localparam int SW = $clog2(DEPTH);

    logic          add_internal_valid;
    logic [63:0]   add_order_ref;
    logic          delete_internal_valid;
    logic [63:0]   delete_order_ref;
    logic          flush;

    logic          trk_add_ok;
    logic          trk_add_dup;
    logic          trk_add_dropped;
    logic          trk_delete_hit;
    logic          trk_delete_miss;
    logic [SW-1:0] trk_slot;
    logic [SW:0]   trk_count;
    logic          trk_full;
`ifdef ORDER_TRACKER_STATS_EN
    logic [31:0]   trk_hit_total;
    logic [31:0]   trk_miss_total;
`endif

    // Decoder side: drives events, observes results.
    modport master (
        output add_internal_valid, add_order_ref,
        output delete_internal_valid, delete_order_ref, flush,
        input  trk_add_ok, trk_add_dup, trk_add_dropped,
        input  trk_delete_hit, trk_delete_miss,
        input  trk_slot, trk_count, trk_full
`ifdef ORDER_TRACKER_STATS_EN
        , input trk_hit_total, trk_miss_total
`endif
    );

    // Tracker side: consumes events, produces results.
    modport slave (
        input  add_internal_valid, add_order_ref,
        input  delete_internal_valid, delete_order_ref, flush,
        output trk_add_ok, trk_add_dup, trk_add_dropped,
        output trk_delete_hit, trk_delete_miss,
        output trk_slot, trk_count, trk_full
`ifdef ORDER_TRACKER_STATS_EN
        , output trk_hit_total, trk_miss_total
`endif
    );
endinterface

// File: rtl/order_ref_tracker.sv
// order_ref_tracker: table of live 64-bit order references.
// Adds insert into the lowest free slot, deletes free the matching slot, and
// every event yields a registered one-cycle result pulse.
// Optional macro ORDER_TRACKER_STATS_EN adds saturating hit/miss totals.
module order_ref_tracker #(
    parameter int DEPTH = 16
) (
    input logic               clk,
    input logic               rst,
    order_ref_tracker_if.slave bus
);
    localparam int SW = $clog2(DEPTH);

    logic [DEPTH-1:0] entry_valid;
    logic [63:0]      entry_ref [DEPTH];

    logic [DEPTH-1:0] add_match;
    logic [DEPTH-1:0] del_match;
    logic [SW-1:0]    free_slot;
    logic [SW-1:0]    del_slot;
    logic             add_present;
    logic             del_present;
    logic             table_full;
    logic             add_ok;
    logic             add_dup;
    logic             add_dropped;
    logic             del_hit;
    logic             del_miss;
    logic [SW:0]      count_next;

    // Parallel compare of both incoming refs against the pre-cycle table.
    always_comb begin
        add_match = '0;
        del_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            add_match[i] = entry_valid[i] && (entry_ref[i] == bus.add_order_ref);
            del_match[i] = entry_valid[i] && (entry_ref[i] == bus.delete_order_ref);
        end
    end

    // Lowest free slot and the (unique) delete match index; scanning downward
    // lets the last assignment win, which is the lowest index.
    always_comb begin
        free_slot = '0;
        del_slot  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entry_valid[i]) free_slot = SW'(i);
            if (del_match[i])    del_slot  = SW'(i);
        end
    end

    // Event classification; a same-cycle delete never makes room for the add.
    always_comb begin
        add_present = |add_match;
        del_present = |del_match;
        table_full  = &entry_valid;
        del_hit     = bus.delete_internal_valid && del_present;
        del_miss    = bus.delete_internal_valid && !del_present;
        add_dup     = bus.add_internal_valid && add_present;
        add_dropped = bus.add_internal_valid && !add_present && table_full;
        add_ok      = bus.add_internal_valid && !add_present && !table_full;
        count_next  = bus.trk_count + {{SW{1'b0}}, add_ok} - {{SW{1'b0}}, del_hit};
    end

    // Valid bits: cleared by reset/flush, otherwise updated by hit and insert.
    // The add slot is always a free entry, so it never collides with the delete slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid <= '0;
        end else if (bus.flush) begin
            entry_valid <= '0;
        end else begin
            if (del_hit) entry_valid[del_slot]  <= 1'b0;
            if (add_ok)  entry_valid[free_slot] <= 1'b1;
        end
    end

    // Ref storage is not reset; an entry is only meaningful while its valid bit is set.
    always_ff @(posedge clk) begin
        if (add_ok) entry_ref[free_slot] <= bus.add_order_ref;
    end

    // Registered result pulses, slot report, live count and full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.trk_add_ok      <= 1'b0;
            bus.trk_add_dup     <= 1'b0;
            bus.trk_add_dropped <= 1'b0;
            bus.trk_delete_hit  <= 1'b0;
            bus.trk_delete_miss <= 1'b0;
            bus.trk_slot        <= '0;
            bus.trk_count       <= '0;
            bus.trk_full        <= 1'b0;
        end else if (bus.flush) begin
            bus.trk_add_ok      <= 1'b0;
            bus.trk_add_dup     <= 1'b0;
            bus.trk_add_dropped <= 1'b0;
            bus.trk_delete_hit  <= 1'b0;
            bus.trk_delete_miss <= 1'b0;
            bus.trk_count       <= '0;
            bus.trk_full        <= 1'b0;
        end else begin
            bus.trk_add_ok      <= add_ok;
            bus.trk_add_dup     <= add_dup;
            bus.trk_add_dropped <= add_dropped;
            bus.trk_delete_hit  <= del_hit;
            bus.trk_delete_miss <= del_miss;
            if (add_ok) begin
                bus.trk_slot <= free_slot;
            end else if (del_hit) begin
                bus.trk_slot <= del_slot;
            end
            bus.trk_count <= count_next;
            bus.trk_full  <= (count_next == (SW + 1)'(DEPTH));
        end
    end

`ifdef ORDER_TRACKER_STATS_EN
    // Saturating totals of hit/miss pulses; survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.trk_hit_total  <= '0;
            bus.trk_miss_total <= '0;
        end else if (!bus.flush) begin
            if (del_hit && (bus.trk_hit_total != 32'hFFFF_FFFF)) begin
                bus.trk_hit_total <= bus.trk_hit_total + 32'd1;
            end
            if (del_miss && (bus.trk_miss_total != 32'hFFFF_FFFF)) begin
                bus.trk_miss_total <= bus.trk_miss_total + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_order_ref_tracker.sv
// Self-checking bench for order_ref_tracker (DEPTH=4): directed test plan
// followed by a randomized phase against a behavioural table model.
module tb_order_ref_tracker;
    localparam int DEPTH = 4;
    localparam int SW    = $clog2(DEPTH);
    localparam int W     = 5 + SW + (SW + 1) + 1;

    logic clk;
    logic rst;

    order_ref_tracker_if #(.DEPTH(DEPTH)) bus ();

    order_ref_tracker #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_vec;
    int n_err;

    // behavioural table model
    logic [DEPTH-1:0] m_valid;
    logic [63:0]      m_ref [DEPTH];
    int               m_count;
    int               m_slot;
    longint unsigned  m_hit_tot;
    longint unsigned  m_miss_tot;

    function automatic logic [W-1:0] pack(input logic ok, input logic dup, input logic drop,
                                          input logic hit, input logic miss, input int slot,
                                          input int count, input logic full);
        logic [SW-1:0] s;
        logic [SW:0]   c;
        s = SW'(slot);
        c = (SW + 1)'(count);
        return {ok, dup, drop, hit, miss, s, c, full};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model one cycle and push the expected outputs.
    task automatic model_cycle(input logic av, input logic [63:0] ar, input logic dv,
                               input logic [63:0] dr, input logic fl, input logic r);
        logic hit, dup, miss, ok, drop, full;
        int hidx, fidx;
        if (r) begin
            m_valid = '0; m_count = 0; m_slot = 0; m_hit_tot = 0; m_miss_tot = 0;
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0));
        end else if (fl) begin
            m_valid = '0; m_count = 0;
            exp_q.push_back(pack(0, 0, 0, 0, 0, m_slot, 0, 0));
        end else begin
            hit = 0; dup = 0; hidx = 0; fidx = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (dv && m_valid[i] && m_ref[i] == dr) begin hit = 1; hidx = i; end
                if (av && m_valid[i] && m_ref[i] == ar) dup = 1;
            end
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) fidx = i;
            full = (m_count == DEPTH);
            miss = dv && !hit;
            ok   = av && !dup && !full;
            drop = av && !dup && full;
            if (hit) m_valid[hidx] = 1'b0;
            if (ok) begin m_valid[fidx] = 1'b1; m_ref[fidx] = ar; end
            if (ok) m_slot = fidx;
            else if (hit) m_slot = hidx;
            m_count = m_count + (ok ? 1 : 0) - (hit ? 1 : 0);
            if (hit && m_hit_tot != 64'hFFFF_FFFF) m_hit_tot++;
            if (miss && m_miss_tot != 64'hFFFF_FFFF) m_miss_tot++;
            exp_q.push_back(pack(ok, dup, drop, hit, miss, m_slot, m_count, m_count == DEPTH));
        end
    endtask

    // driver: apply one cycle of stimulus, then compare one cycle later
    task automatic step(input string tag, input logic av, input logic [63:0] ar,
                        input logic dv, input logic [63:0] dr, input logic fl, input logic r);
        logic [W-1:0] obs;
        logic [W-1:0] e;
        bus.add_internal_valid    = av;
        bus.add_order_ref         = ar;
        bus.delete_internal_valid = dv;
        bus.delete_order_ref      = dr;
        bus.flush                 = fl;
        rst                       = r;
        model_cycle(av, ar, dv, dr, fl, r);
        @(posedge clk);
        #1;
        obs = {bus.trk_add_ok, bus.trk_add_dup, bus.trk_add_dropped, bus.trk_delete_hit,
               bus.trk_delete_miss, bus.trk_slot, bus.trk_count, bus.trk_full};
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(obs), 64'(e));
        end
`ifdef ORDER_TRACKER_STATS_EN
        check({tag, "_hit_tot"},  64'(bus.trk_hit_total),  m_hit_tot);
        check({tag, "_miss_tot"}, 64'(bus.trk_miss_total), m_miss_tot);
`endif
        bus.add_internal_valid    = 1'b0;
        bus.delete_internal_valid = 1'b0;
        bus.flush                 = 1'b0;
        rst                       = 1'b0;
    endtask

    task automatic add(input string tag, input logic [63:0] ar);
        step(tag, 1'b1, ar, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic del(input string tag, input logic [63:0] dr);
        step(tag, 1'b0, 64'd0, 1'b1, dr, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_valid = '0; m_count = 0; m_slot = 0; m_hit_tot = 0; m_miss_tot = 0;
        bus.add_internal_valid = 1'b0;
        bus.add_order_ref = '0;
        bus.delete_internal_valid = 1'b0;
        bus.delete_order_ref = '0;
        bus.flush = 1'b0;
        rst = 1'b1;

        step("reset", 0, 64'd0, 0, 64'd0, 0, 1);

        // basic add then delete three cycles later
        add("add_basic", 64'h1122_3344_5566_7788);
        idle("idle_a");
        idle("idle_b");
        del("del_basic", 64'h1122_3344_5566_7788);

        // unknown delete on empty table
        del("del_unknown", 64'hDEAD_BEEF);

        // duplicate add and fill
        add("add_a", 64'hA);
        add("add_a_dup", 64'hA);
        add("add_b", 64'hB);
        add("add_c", 64'hC);
        add("add_d_full", 64'hD);
        add("add_e_drop", 64'hE);

        // simultaneous events on full table: freed slot not usable same cycle
        step("sim_del_b_add_e", 1, 64'hE, 1, 64'hB, 0, 0);
        add("add_e_slot1", 64'hE);

        // flush and reset
        step("reset2", 0, 64'd0, 0, 64'd0, 0, 1);
        add("f_add_a", 64'hA);
        add("f_add_b", 64'hB);
        add("f_add_c", 64'hC);
        step("flush_evt", 1, 64'hD, 1, 64'hB, 1, 0);
        del("del_a_after_flush", 64'hA);
        add("pre_rst_add", 64'h55);
        step("rst_mid", 1, 64'h66, 1, 64'h55, 0, 1);
        idle("after_rst");

        // same ref on both sides
        step("same_absent", 1, 64'h77, 1, 64'h77, 0, 0);
        step("same_present", 1, 64'h77, 1, 64'h77, 0, 0);
        del("same_gone", 64'h77);

        // stats-style sequence: 2 hits, 3 misses, then flush
        step("reset3", 0, 64'd0, 0, 64'd0, 0, 1);
        add("s_add_p", 64'h100);
        add("s_add_q", 64'h200);
        del("s_hit_p", 64'h100);
        del("s_hit_q", 64'h200);
        del("s_miss1", 64'h300);
        del("s_miss2", 64'h301);
        del("s_miss3", 64'h302);
        step("s_flush", 0, 64'd0, 0, 64'd0, 1, 0);
        idle("s_after_flush");

        // randomized traffic over a small ref pool to provoke dup/hit/full cases
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)), 64'($urandom_range(1, 6)),
                 1'($urandom_range(0, 1)), 64'($urandom_range(1, 6)),
                 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 99) == 0));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
